// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the 16-bit SRAM arbiter/controller.
// Round-robin arbitration is enabled elsewhere by defining SRAM_RR_ARB_EN.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

    localparam int SRAM_DW = 16;
    localparam int SRAM_AW = 18;
    localparam int WORD_AW = SRAM_AW - 1;

    // Word index is off[18:2]; the subtraction wraps modulo 2^32.
    function automatic logic [WORD_AW-1:0] map_word(input logic [31:0] addr,
                                                    input logic [31:0] base);
        return WORD_AW'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_io_drv.sv
// Half-phase timer, OE_N/WE_N strobe timing, DQ tristate drive and read capture.
// A phase lasts SRAM_WAIT cycles; on writes the last cycle is a WE_N-high hold cycle.
module sram_io_drv
    import sram_ctrl_pkg::*;
#(
    parameter int SRAM_WAIT = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               active,
    input  logic               hi_half,
    input  logic               we,
    input  logic [31:0]        wdata,
    inout  wire  [SRAM_DW-1:0] dq,
    output logic               oe_n,
    output logic               we_n,
    output logic               phase_done,
    output logic               cap_lo,
    output logic               cap_hi,
    output logic [SRAM_DW-1:0] cap_data
);

    localparam int CW = 4;
    localparam logic [CW-1:0] LAST = CW'(SRAM_WAIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          drive;

    always_comb begin
        phase_done = active && (cnt_q == LAST);
        drive      = active && we;
        oe_n       = !(active && !we);
        we_n       = !(drive && !phase_done);
        cap_lo     = phase_done && !we && !hi_half;
        cap_hi     = phase_done && !we && hi_half;
        cap_data   = dq;
    end

    always_comb begin
        cnt_d = '0;
        if (active && !phase_done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Driven purely from state, so an async reset releases the bus at once.
    assign dq = drive ? (hi_half ? wdata[31:16] : wdata[15:0]) : 'z;

endmodule

// File: rtl/sram_arbiter_ctrl.sv
// Two-port (data D / instruction I) arbiter sharing one 16-bit SRAM; each 32-bit
// access is a LO then HI half cycle. Define SRAM_RR_ARB_EN for round-robin arbitration.
module sram_arbiter_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int          SRAM_WAIT = 3,
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [31:0]        d_addr,
    input  logic [31:0]        d_wdata,
    output logic [31:0]        d_rdata,
    output logic               d_ready,
    output logic               d_stall,
    input  logic               i_req,
    input  logic [31:0]        i_addr,
    output logic [31:0]        i_rdata,
    output logic               i_ready,
    output logic               i_stall,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_WE_N
);

    state_e               state_q, state_d;
    logic                 port_q, port_d;
    logic                 we_q, we_d;
    logic [WORD_AW-1:0]   word_q, word_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          d_rdata_q, d_rdata_d;
    logic [31:0]          i_rdata_q, i_rdata_d;
    logic                 any_req, grant_port, grant_now;
    logic                 active, hi_half;
    logic                 phase_done, cap_lo, cap_hi;
    logic [SRAM_DW-1:0]   cap_data;

    assign any_req   = d_req || i_req;
    assign grant_now = (state_q == ST_IDLE) && any_req;

`ifdef SRAM_RR_ARB_EN
    logic ptr_q, ptr_d;

    always_comb begin
        grant_port = d_req ? PORT_D : PORT_I;
        if (d_req && i_req) begin
            grant_port = ptr_q;
        end
        ptr_d = grant_now ? ~ptr_q : ptr_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= PORT_D;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        grant_port = d_req ? PORT_D : PORT_I;
    end
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (any_req)    state_d = ST_LO;
            ST_LO:   if (phase_done) state_d = ST_HI;
            ST_HI:   if (phase_done) state_d = ST_DONE;
            ST_DONE:                 state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Request latch on grant and per-port read-data halves.
    always_comb begin
        port_d    = port_q;
        we_d      = we_q;
        word_d    = word_q;
        wdata_d   = wdata_q;
        d_rdata_d = d_rdata_q;
        i_rdata_d = i_rdata_q;
        if (grant_now) begin
            port_d  = grant_port;
            we_d    = (grant_port == PORT_D) && d_we;
            word_d  = map_word((grant_port == PORT_D) ? d_addr : i_addr, BASE_ADDR);
            wdata_d = d_wdata;
        end
        if (cap_lo && port_q == PORT_D) d_rdata_d[15:0]  = cap_data;
        if (cap_hi && port_q == PORT_D) d_rdata_d[31:16] = cap_data;
        if (cap_lo && port_q == PORT_I) i_rdata_d[15:0]  = cap_data;
        if (cap_hi && port_q == PORT_I) i_rdata_d[31:16] = cap_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            port_q    <= PORT_D;
            we_q      <= 1'b0;
            word_q    <= '0;
            wdata_q   <= '0;
            d_rdata_q <= '0;
            i_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            we_q      <= we_d;
            word_q    <= word_d;
            wdata_q   <= wdata_d;
            d_rdata_q <= d_rdata_d;
            i_rdata_q <= i_rdata_d;
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        active    = (state_q == ST_LO) || (state_q == ST_HI);
        hi_half   = (state_q == ST_HI);
        SRAM_ADDR = active ? {word_q, hi_half} : '0;
        d_ready   = (state_q == ST_DONE) && (port_q == PORT_D);
        i_ready   = (state_q == ST_DONE) && (port_q == PORT_I);
        d_stall   = d_req && !d_ready;
        i_stall   = i_req && !i_ready;
        d_rdata   = d_rdata_q;
        i_rdata   = i_rdata_q;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
        SRAM_CE_N = 1'b0;
    end

    sram_io_drv #(
        .SRAM_WAIT(SRAM_WAIT)
    ) u_io (
        .clock      (clock),
        .reset      (reset),
        .active     (active),
        .hi_half    (hi_half),
        .we         (we_q),
        .wdata      (wdata_q),
        .dq         (SRAM_DQ),
        .oe_n       (SRAM_OE_N),
        .we_n       (SRAM_WE_N),
        .phase_done (phase_done),
        .cap_lo     (cap_lo),
        .cap_hi     (cap_hi),
        .cap_data   (cap_data)
    );

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Bench for sram_arbiter_ctrl: SRAM device model, port drivers and a reference
// memory/latency model derived from the access rules.
module tb_sram_arbiter_ctrl;

  localparam int W   = 3;
  localparam int LAT = 2 * W + 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        d_req, d_we, i_req;
  logic [31:0] d_addr, d_wdata, i_addr;
  logic [31:0] d_rdata, i_rdata;
  logic        d_ready, d_stall, i_ready, i_stall;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n, sram_we_n;

  sram_arbiter_ctrl #(.SRAM_WAIT(W), .BASE_ADDR(32'd1024)) dut (
    .clock(clock), .reset(reset),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
    .i_ready(i_ready), .i_stall(i_stall),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
    .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n), .SRAM_CE_N(sram_ce_n),
    .SRAM_OE_N(sram_oe_n), .SRAM_WE_N(sram_we_n)
  );

  // Clock / reset
  always #5 clock = ~clock;

  // SRAM device model
  logic [15:0] mem [0:262143];
  assign sram_dq = !sram_oe_n ? mem[sram_addr] : 16'hzzzz;

  // Reference state
  logic [15:0] ref_mem [int];
  logic [31:0] last_d_rd, last_i_rd;
  bit          rr_ptr;
  int          we_low_cnt, strobe_clash, exp_we_low;
  logic [0:0]  exp_q[$];
  logic [0:0]  order_q[$];
  int          n_checks, n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [15:0] ref_rd(input int hw);
    return ref_mem.exists(hw) ? ref_mem[hw] : 16'h0000;
  endfunction

  function automatic int hw_of(input logic [31:0] a);
    return int'(((a - 32'd1024) >> 2) & 32'h0001_FFFF) * 2;
  endfunction

  task automatic preload(input int hw, input logic [15:0] v);
    mem[hw] = v;
    ref_mem[hw] = v;
  endtask

  task automatic sram_model();
    forever begin
      @(negedge clock);
      if (!sram_we_n) begin
        mem[sram_addr] = sram_dq;
        we_low_cnt++;
      end
      if (!sram_we_n && !sram_oe_n) strobe_clash++;
    end
  endtask

  // Drives one request on a port and scores it on completion.
  task automatic port_access(input bit is_i, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int exp_lat);
    int n;
    bit seen;
    int hw;
    logic [31:0] exp_rd;
    n = 0;
    seen = 0;
    if (is_i) begin
      i_req = 1'b1; i_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end
    while (!seen && n < 64) begin
      @(negedge clock);
      if (is_i ? i_ready : d_ready) seen = 1;
      else begin
        check(is_i ? "i_stall_wait" : "d_stall_wait", 32'(is_i ? i_stall : d_stall), 32'd1);
        n++;
      end
    end
    if (!seen) begin
      check(is_i ? "i_ready_timeout" : "d_ready_timeout", 32'(n), 32'(exp_lat));
    end else begin
      order_q.push_back(is_i);
      rr_ptr = !rr_ptr;
      hw = hw_of(addr);
      check(is_i ? "i_latency" : "d_latency", 32'(n), 32'(exp_lat));
      check(is_i ? "i_stall_done" : "d_stall_done", 32'(is_i ? i_stall : d_stall), 32'd0);
      if (!is_i && we) begin
        ref_mem[hw]     = wdata[15:0];
        ref_mem[hw + 1] = wdata[31:16];
        exp_we_low += 2 * (W - 1);
        check("d_rdata_after_write", d_rdata, last_d_rd);
      end else begin
        exp_rd = {ref_rd(hw + 1), ref_rd(hw)};
        if (is_i) begin
          check("i_rdata", i_rdata, exp_rd); last_i_rd = exp_rd;
        end else begin
          check("d_rdata", d_rdata, exp_rd); last_d_rd = exp_rd;
        end
      end
    end
    @(posedge clock);
    #1;
    if (is_i) i_req = 1'b0;
    else d_req = 1'b0;
  endtask

  task automatic run_pair(input bit dwe, input logic [31:0] da, input logic [31:0] wd,
                          input logic [31:0] ia);
    bit d_first;
`ifdef SRAM_RR_ARB_EN
    d_first = (rr_ptr == 1'b0);
`else
    d_first = 1'b1;
`endif
    fork
      port_access(1'b0, dwe, da, wd, d_first ? LAT : 2 * LAT + 1);
      port_access(1'b1, 1'b0, ia, 32'h0, d_first ? 2 * LAT + 1 : LAT);
    join
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'd1024 + 32'($urandom_range(16, 31)) * 4 + 32'($urandom_range(0, 3))
           + (32'($urandom_range(0, 1)) << 19);
  endfunction

  int          mode, we_base;
  logic [31:0] ra, rb, rw;
  bit          rwe;

  initial begin
    reset = 1'b0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; i_req = 0; i_addr = 0;
    n_checks = 0; n_pass = 0; rr_ptr = 0;
    we_low_cnt = 0; strobe_clash = 0; exp_we_low = 0;
    last_d_rd = 0; last_i_rd = 0;
    for (int k = 0; k < 128; k++) mem[k] = 16'h0000;
    mem[262142] = 16'h0000; mem[262143] = 16'h0000;
    preload(0, 16'hBEEF); preload(1, 16'hDEAD);
    preload(262142, 16'h4321); preload(262143, 16'h8765);
    fork sram_model(); join_none

    repeat (2) @(negedge clock);
    check("rst_d_ready", 32'(d_ready), 32'd0);
    check("rst_i_ready", 32'(i_ready), 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_oe_we_n", {30'd0, sram_oe_n, sram_we_n}, 32'd3);
    check("rst_ub_lb_ce_n", {29'd0, sram_ub_n, sram_lb_n, sram_ce_n}, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Directed read, write and wrapped mapping
    port_access(1'b0, 1'b0, 32'd1024, 32'h0, LAT);
    check("read_deadbeef", d_rdata, 32'hDEADBEEF);
    we_base = we_low_cnt;
    port_access(1'b0, 1'b1, 32'd1032, 32'h12345678, LAT);
    check("write_hw4", 32'(mem[4]), 32'h5678);
    check("write_hw5", 32'(mem[5]), 32'h1234);
    check("write_we_low_cycles", 32'(we_low_cnt - we_base), 32'd4);
    fork
      port_access(1'b1, 1'b0, 32'd1020, 32'h0, LAT);
      begin
        repeat (2) @(negedge clock);
        check("wrap_addr_lo", 32'(sram_addr), 32'h3FFFE);
        check("wrap_oe_lo", 32'(sram_oe_n), 32'd0);
        repeat (3) @(negedge clock);
        check("wrap_addr_hi", 32'(sram_addr), 32'h3FFFF);
      end
    join
    run_pair(1'b0, 32'd1024, 32'h0, 32'd1032);

    // Randomized traffic
    we_base = we_low_cnt;
    exp_we_low = 0;
    for (int it = 0; it < 30; it++) begin
      mode = $urandom_range(0, 2);
      ra = rand_addr(); rb = rand_addr(); rw = $urandom(); rwe = 1'($urandom_range(0, 1));
      if (mode == 0) port_access(1'b0, rwe, ra, rw, LAT);
      else if (mode == 1) port_access(1'b1, 1'b0, rb, 32'h0, LAT);
      else run_pair(rwe, ra, rw, rb);
    end
    check("rand_we_low_cycles", 32'(we_low_cnt - we_base), 32'(exp_we_low));
    check("strobe_clash", 32'(strobe_clash), 32'd0);
    for (int hw = 32; hw < 64; hw++) check("mem_vs_ref", 32'(mem[hw]), 32'(ref_rd(hw)));

    // Async reset in cycle 3 of a write
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd1040; d_wdata = 32'hCAFEF00D;
    repeat (4) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check("arst_we_n", 32'(sram_we_n), 32'd1);
    check("arst_oe_n", 32'(sram_oe_n), 32'd1);
    check("arst_addr", 32'(sram_addr), 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    rr_ptr = 0; last_d_rd = 0; last_i_rd = 0;
    repeat (2) begin
      @(negedge clock);
      check("arst_no_ready", 32'(d_ready), 32'd0);
    end
    reset = 1'b1;
    repeat (10) begin
      @(negedge clock);
      check("post_arst_no_ready", 32'(d_ready), 32'd0);
    end
    check("arst_hi_unwritten", 32'(mem[9]), 32'd0);
    check("arst_d_rdata", d_rdata, 32'd0);
    @(posedge clock); #1;

    // Both ports requesting continuously for four accesses
    order_q.delete();
    exp_q.delete();
`ifdef SRAM_RR_ARB_EN
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    fork
      begin
        port_access(1'b0, 1'b0, 32'd1088, 32'h0, LAT);
        port_access(1'b0, 1'b0, 32'd1092, 32'h0, 2 * LAT + 1);
      end
      begin
        port_access(1'b1, 1'b0, 32'd1096, 32'h0, 2 * LAT + 1);
        port_access(1'b1, 1'b0, 32'd1100, 32'h0, 2 * LAT + 1);
      end
    join
`else
    exp_q = '{1'b0, 1'b0, 1'b1, 1'b1};
    fork
      begin
        port_access(1'b0, 1'b0, 32'd1088, 32'h0, LAT);
        port_access(1'b0, 1'b0, 32'd1092, 32'h0, LAT);
      end
      begin
        port_access(1'b1, 1'b0, 32'd1096, 32'h0, 3 * LAT + 2);
        port_access(1'b1, 1'b0, 32'd1100, 32'h0, LAT);
      end
    join
`endif
    check("grant_order_len", 32'(order_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < order_q.size(); k++)
      check("grant_order", 32'(order_q[k]), 32'(exp_q[k]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter_ctrl.md
Name: sram_arbiter_ctrl

Overview:
- Shares the single 16-bit off-chip SRAM between two 32-bit requesters: data port (MEM stage, port D) and instruction port (IF stage, port I).
- Each 32-bit access is split into two sequenced 16-bit SRAM cycles, low half then high half.
- Produces per-port ready pulses and combinational stall signals that drive pipeline freeze.

Parameters:
- SRAM_WAIT, 3: cycles per 16-bit half-phase; legal range 2..15.
- BASE_ADDR, 1024: byte address subtracted from requester addresses before mapping.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- d_req  in  1  data-port request; held until d_ready
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data byte address
- d_wdata  in  32  data-port store value
- d_rdata  out  32  data-port load result; valid while d_ready = 1
- d_ready  out  1  one-cycle completion pulse
- d_stall  out  1  d_req & ~d_ready (combinational)
- i_req  in  1  instruction-port request (read-only); held until i_ready
- i_addr  in  32  instruction byte address
- i_rdata  out  32  fetched word; valid while i_ready = 1
- i_ready  out  1  one-cycle completion pulse
- i_stall  out  1  i_req & ~i_ready (combinational)
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_ADDR  out  18  SRAM half-word address
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N  out  1 each  tied 0 after reset
- SRAM_OE_N, SRAM_WE_N  out  1 each  active-low read and write strobes

Behaviour:
- Reset values (asynchronous, active-low):
  - State IDLE.
  - All ready outputs 0; d_rdata = i_rdata = 0.
  - SRAM_ADDR = 0; OE_N = WE_N = 1; UB_N = LB_N = CE_N = 0.
  - DQ = high-Z.
  - Round-robin pointer = D.
- Address mapping:
  - off = addr - BASE_ADDR, modulo 2^32.
  - Word index = off[18:2]. off[1:0] and off[31:19] are ignored.
  - Low half at {off[18:2], 1'b0}; high half at {off[18:2], 1'b1}.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: if any req, grant and latch port, we, address and wdata; go to LO. Otherwise stay.
  - LO: lasts SRAM_WAIT cycles, counter from 0 to SRAM_WAIT-1; then go to HI.
  - HI: same length as LO; then go to DONE.
  - DONE: exactly 1 cycle. The granted port's ready = 1; then go to IDLE.
- Read phase:
  - OE_N = 0 for the whole phase; DQ high-Z.
  - DQ is captured on the final cycle of the phase into the rdata half-register: LO fills [15:0], HI fills [31:16].
- Write phase:
  - DQ is driven with wdata[15:0] in LO and wdata[31:16] in HI, for the whole phase.
  - WE_N = 0 on all cycles except the final one, which is the hold cycle with WE_N = 1.
  - OE_N = 1.
- Latency: req sampled in IDLE at edge 0 gives ready high in cycle 2*SRAM_WAIT+1. Default: cycle 7.
- Non-granted port: its req is ignored until the FSM returns to IDLE; its stall stays 1.
- rdata registers hold their value until the next access of the same port.
- A request seen in IDLE on the cycle after DONE is treated as a new access. Requesters advance on the ready edge.
- Simultaneous d_req and i_req in IDLE: D wins (fixed priority); see Optional Feature.
- Reset mid-access: the access is abandoned immediately, DQ is released asynchronously, and no ready pulse is issued.
- Write with d_we = 1 leaves d_rdata unchanged.

Optional Feature:
- SRAM_RR_ARB_EN defined:
  - Simultaneous requests go to the port named by the pointer.
  - The pointer toggles to the other port after every granted access.
  - A single requester is always served regardless of the pointer.
- Undefined: fixed priority D > I. I can starve while D requests back-to-back.

Decomposition:
- Package sram_ctrl_pkg:
  - State enum (IDLE, LO, HI, DONE).
  - Port-id constants PORT_D and PORT_I.
  - SRAM_DW = 16 and SRAM_AW = 18.
  - Address-mapping function.
- Sub-module sram_io_drv:
  - Counts the half-phase length.
  - Generates OE_N/WE_N timing and DQ tristate drive.
  - Captures read data; flags phase_done to the FSM.

Test Plan:
- Read: preload SRAM hw 0 = 0xBEEF, hw 1 = 0xDEAD; d_req=1, d_we=0, d_addr=1024 -> d_ready pulses in cycle 7 with d_rdata = 0xDEADBEEF; d_stall = 1 in cycles 0-6.
- Write: d_we=1, d_addr=1032, d_wdata=0x12345678 -> SRAM hw 4 = 0x5678, hw 5 = 0x1234; WE_N low exactly 2 cycles per half, high on the hold cycle.
- Conflict: d_req and i_req rise together -> D served first (ready cycle 7); I granted in the next IDLE, i_ready in cycle 15; i_stall = 1 throughout until then.
- SRAM_RR_ARB_EN: both ports request continuously for 4 accesses -> grant order D, I, D, I.
- Async reset asserted in cycle 3 of a write -> DQ high-Z and WE_N = 1 in the same cycle; no ready pulse; only the low half is possibly written.
- Wrap mapping: i_addr = 1020 -> off = 0xFFFFFFFC -> word index 0x1FFFF, SRAM_ADDR = 0x3FFFE then 0x3FFFF.
